// File: rtl/g3f_ramp_ctrl.sv
// Ramp/sequencing controller for the three-phase generator: slews the phase
// increment toward a commanded target, reversing through zero and decelerating on stop.
module g3f_ramp_ctrl #(
    parameter int INC_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [INC_W-1:0]   cmd_target,
    input  logic               cmd_dir,
    input  logic [7:0]         cmd_step,
    input  logic [PRESC_W-1:0] cmd_div,
    input  logic               stop,
    output logic [INC_W-1:0]   inc_out,
    output logic               dir_out,
    output logic               gen_en,
    output logic               busy,
    output logic               at_target
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_REVERSE,
        ST_STOPPING
    } state_t;

    state_t               state_reg;
    logic [INC_W-1:0]     inc_reg;
    logic [INC_W-1:0]     target_reg;
    logic                 dir_reg;
    logic [7:0]           step_reg;
    logic [PRESC_W-1:0]   div_reg;
    logic [PRESC_W-1:0]   presc_reg;

    logic [INC_W-1:0]     step_eff;
    logic [INC_W:0]       up_sum;
    logic [INC_W-1:0]     up_sat;
    logic [INC_W-1:0]     up_next;
    logic [INC_W-1:0]     dn_next;
    logic [INC_W-1:0]     ramp_next;
    logic [INC_W-1:0]     zero_next;
    logic [PRESC_W-1:0]   presc_adv;
    logic                 tick;
    logic                 accept;

    // A zero step would stall the ramp forever, so it behaves as a step of one.
    always_comb begin
        step_eff      = '0;
        step_eff[7:0] = (step_reg == 8'd0) ? 8'd1 : step_reg;
    end

    // Extra carry bit lets the up-step saturate instead of wrapping before the clamp.
    assign up_sum    = {1'b0, inc_reg} + {1'b0, step_eff};
    assign up_sat    = up_sum[INC_W] ? {INC_W{1'b1}} : up_sum[INC_W-1:0];
    assign up_next   = (up_sat > target_reg) ? target_reg : up_sat;
    assign dn_next   = ((inc_reg - target_reg) <= step_eff) ? target_reg : (inc_reg - step_eff);
    assign ramp_next = (inc_reg < target_reg) ? up_next : dn_next;
    assign zero_next = (inc_reg <= step_eff) ? '0 : (inc_reg - step_eff);

    assign tick      = (presc_reg == div_reg);
    assign presc_adv = tick ? '0 : (presc_reg + 1'b1);

    assign cmd_ready = ena && !stop && ((state_reg == ST_IDLE) || (state_reg == ST_HOLD));
    assign accept    = cmd_valid && cmd_ready;

    assign inc_out   = inc_reg;
    assign dir_out   = dir_reg;
    assign gen_en    = (inc_reg != '0);
    assign busy      = (state_reg == ST_RAMP) || (state_reg == ST_REVERSE) ||
                       (state_reg == ST_STOPPING);
    assign at_target = (state_reg == ST_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            inc_reg    <= '0;
            target_reg <= '0;
            dir_reg    <= 1'b0;
            step_reg   <= '0;
            div_reg    <= '0;
            presc_reg  <= '0;
        end else if (ena) begin
            if (stop && (state_reg != ST_IDLE) && (state_reg != ST_STOPPING)) begin
                // Deceleration keeps the running prescaler phase rather than restarting it.
                state_reg <= ST_STOPPING;
                presc_reg <= presc_adv;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_HOLD: begin
                        if (accept) begin
                            target_reg <= cmd_target;
                            step_reg   <= cmd_step;
                            div_reg    <= cmd_div;
                            presc_reg  <= '0;
                            if (cmd_dir != dir_reg) begin
                                if (inc_reg != '0) begin
                                    state_reg <= ST_REVERSE;
                                end else begin
                                    dir_reg   <= cmd_dir;
                                    state_reg <= (cmd_target == '0) ? ST_IDLE : ST_RAMP;
                                end
                            end else if (cmd_target == inc_reg) begin
                                state_reg <= (inc_reg == '0) ? ST_IDLE : ST_HOLD;
                            end else begin
                                state_reg <= ST_RAMP;
                            end
                        end
                    end
                    ST_RAMP: begin
                        presc_reg <= presc_adv;
                        if (tick) begin
                            inc_reg <= ramp_next;
                            if (ramp_next == target_reg) begin
                                state_reg <= ST_HOLD;
                            end
                        end
                    end
                    ST_REVERSE: begin
                        if (inc_reg == '0) begin
                            dir_reg   <= ~dir_reg;
                            presc_reg <= '0;
                            state_reg <= (target_reg == '0) ? ST_IDLE : ST_RAMP;
                        end else begin
                            presc_reg <= presc_adv;
                            if (tick) begin
                                inc_reg <= zero_next;
                            end
                        end
                    end
                    ST_STOPPING: begin
                        if (inc_reg == '0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            presc_reg <= presc_adv;
                            if (tick) begin
                                inc_reg <= zero_next;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_g3f_ramp_ctrl.sv
// Bench for g3f_ramp_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_g3f_ramp_ctrl;

    localparam int INC_W   = 16;
    localparam int PRESC_W = 8;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_REV  = 3;
    localparam int M_STOP = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ena = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [INC_W-1:0]   cmd_target = '0;
    logic               cmd_dir = 1'b0;
    logic [7:0]         cmd_step = '0;
    logic [PRESC_W-1:0] cmd_div = '0;
    logic               stop = 1'b0;
    logic [INC_W-1:0]   inc_out;
    logic               dir_out;
    logic               gen_en;
    logic               busy;
    logic               at_target;

    int tests = 0;
    int fails = 0;

    // Behavioural model: frequency as a plain integer, a mode number,
    // and a count of clocks elapsed within the current ramp period.
    int m_mode, m_inc, m_dir, m_tgt, m_step, m_div, m_elapsed;

    g3f_ramp_ctrl #(.INC_W(INC_W), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .cmd_dir   (cmd_dir),
        .cmd_step  (cmd_step),
        .cmd_div   (cmd_div),
        .stop      (stop),
        .inc_out   (inc_out),
        .dir_out   (dir_out),
        .gen_en    (gen_en),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void m_reset();
        m_mode = M_IDLE; m_inc = 0; m_dir = 0; m_tgt = 0;
        m_step = 0; m_div = 0; m_elapsed = 0;
    endfunction

    function automatic void m_advance();
        int  st;
        bit  period_done;
        st          = (m_step == 0) ? 1 : m_step;
        period_done = ((m_elapsed + 1) == (m_div + 1));
        if (stop && m_mode != M_IDLE && m_mode != M_STOP) begin
            m_mode    = M_STOP;
            m_elapsed = period_done ? 0 : m_elapsed + 1;
            return;
        end
        case (m_mode)
            M_IDLE, M_HOLD: begin
                if (cmd_valid && !stop) begin
                    m_tgt = int'(cmd_target); m_step = int'(cmd_step);
                    m_div = int'(cmd_div);    m_elapsed = 0;
                    if (int'(cmd_dir) != m_dir && m_inc != 0) m_mode = M_REV;
                    else if (int'(cmd_dir) != m_dir) begin
                        m_dir  = int'(cmd_dir);
                        m_mode = (m_tgt == 0) ? M_IDLE : M_RAMP;
                    end else if (m_tgt == m_inc) m_mode = (m_inc == 0) ? M_IDLE : M_HOLD;
                    else m_mode = M_RAMP;
                end
            end
            M_RAMP: begin
                m_elapsed = period_done ? 0 : m_elapsed + 1;
                if (period_done) begin
                    if (m_inc < m_tgt) m_inc = imin(imin(m_inc + st, 65535), m_tgt);
                    else               m_inc = imax(m_inc - st, m_tgt);
                    if (m_inc == m_tgt) m_mode = M_HOLD;
                end
            end
            M_REV: begin
                if (m_inc == 0) begin
                    m_dir = 1 - m_dir; m_elapsed = 0;
                    m_mode = (m_tgt == 0) ? M_IDLE : M_RAMP;
                end else begin
                    m_elapsed = period_done ? 0 : m_elapsed + 1;
                    if (period_done) m_inc = imax(m_inc - st, 0);
                end
            end
            default: begin
                if (m_inc == 0) m_mode = M_IDLE;
                else begin
                    m_elapsed = period_done ? 0 : m_elapsed + 1;
                    if (period_done) m_inc = imax(m_inc - st, 0);
                end
            end
        endcase
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else if (ena) m_advance();
        end
    end

    // Every falling edge: all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_inc", int'(inc_out), m_inc);
            chk("cyc_dir", int'(dir_out), m_dir);
            chk("cyc_gen_en", int'(gen_en), int'(m_inc != 0));
            chk("cyc_busy", int'(busy), int'(m_mode == M_RAMP || m_mode == M_REV || m_mode == M_STOP));
            chk("cyc_at_target", int'(at_target), int'(m_mode == M_HOLD));
            chk("cyc_ready", int'(cmd_ready),
                int'(ena && !stop && (m_mode == M_IDLE || m_mode == M_HOLD)));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; stop = 1'b0; cmd_valid = 1'b0;
        repeat (2) step_clk();
        rst_n = 1'b1;
    endtask

    task automatic send(int tgt, int d, int stp, int dv);
        cmd_valid = 1'b1; cmd_target = tgt[INC_W-1:0]; cmd_dir = d[0];
        cmd_step = stp[7:0]; cmd_div = dv[PRESC_W-1:0];
        step_clk();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int r, v;
        // Reset state
        #1;
        chk("rst_inc", int'(inc_out), 0);
        chk("rst_dir", int'(dir_out), 0);
        chk("rst_gen_en", int'(gen_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        do_reset();
        $display("[TB] reset checked");

        // Ramp 0 -> 100, step 10, one tick every 4 clocks
        send(100, 0, 10, 3);
        for (int k = 1; k <= 40; k++) begin
            step_clk();
            chk("ramp_inc", int'(inc_out), 10 * (k / 4));
        end
        chk("ramp_at_target", int'(at_target), 1);
        chk("ramp_ready", int'(cmd_ready), 1);
        $display("[TB] ramp to 100 inc=%0d", inc_out);

        // Clamp at 25 without overshoot
        do_reset();
        send(25, 0, 10, 0);
        step_clk(); chk("clamp_1", int'(inc_out), 10);
        step_clk(); chk("clamp_2", int'(inc_out), 20);
        step_clk(); chk("clamp_3", int'(inc_out), 25);
        chk("clamp_at_target", int'(at_target), 1);
        step_clk(); chk("clamp_hold", int'(inc_out), 25);
        $display("[TB] clamp inc=%0d", inc_out);

        // Reverse through zero
        do_reset();
        send(100, 0, 100, 0);
        step_clk(); chk("rev_pre", int'(inc_out), 100);
        send(50, 1, 20, 0);
        for (int k = 1; k <= 5; k++) begin
            step_clk();
            chk("rev_down", int'(inc_out), 100 - 20 * k);
        end
        chk("rev_gen_en0", int'(gen_en), 0);
        chk("rev_dir_before", int'(dir_out), 0);
        step_clk();
        chk("rev_dir_after", int'(dir_out), 1);
        chk("rev_zero", int'(inc_out), 0);
        step_clk(); chk("rev_up1", int'(inc_out), 20);
        step_clk(); chk("rev_up2", int'(inc_out), 40);
        step_clk(); chk("rev_up3", int'(inc_out), 50);
        chk("rev_hold", int'(at_target), 1);
        $display("[TB] reverse inc=%0d dir=%0d", inc_out, dir_out);

        // Stop mid-ramp; a pending command must not be accepted
        do_reset();
        send(200, 0, 10, 1);
        for (int k = 1; k <= 12; k++) step_clk();
        chk("stop_pre", int'(inc_out), 60);
        stop = 1'b1; cmd_valid = 1'b1; cmd_target = 16'd7; cmd_dir = 1'b0;
        step_clk();
        chk("stop_busy", int'(busy), 1);
        stop = 1'b0;
        for (int k = 14; k <= 25; k++) begin
            step_clk();
            chk("stop_inc", int'(inc_out), 60 - 10 * ((k - 12) / 2));
            if (k <= 24) chk("stop_ready", int'(cmd_ready), 0);
        end
        chk("stop_idle", int'(busy), 0);
        cmd_valid = 1'b0;
        $display("[TB] stop inc=%0d busy=%0d", inc_out, busy);

        // Freeze with ena low, then asynchronous reset mid-ramp
        do_reset();
        send(100, 0, 10, 3);
        for (int k = 1; k <= 6; k++) step_clk();
        chk("frz_pre", int'(inc_out), 10);
        ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step_clk();
            chk("frz_inc", int'(inc_out), 10);
            chk("frz_ready", int'(cmd_ready), 0);
        end
        ena = 1'b1;
        step_clk(); chk("frz_resume1", int'(inc_out), 10);
        step_clk(); chk("frz_resume2", int'(inc_out), 20);
        for (int k = 0; k < 4; k++) step_clk();
        chk("frz_resume3", int'(inc_out), 30);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_inc", int'(inc_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_gen_en", int'(gen_en), 0);
        step_clk();
        rst_n = 1'b1;
        $display("[TB] freeze/async reset inc=%0d", inc_out);

        // Randomized traffic checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            step_clk();
            ena  = ($urandom_range(0, 19) != 0);
            stop = ($urandom_range(0, 59) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r < 2)       v = 0;
            else if (r < 4)  v = m_inc;
            else if (r == 9) v = 65535 - $urandom_range(0, 300);
            else             v = $urandom_range(0, 400);
            cmd_target = v[INC_W-1:0];
            cmd_dir    = $urandom_range(0, 1) != 0;
            v = (r == 9 || $urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 60);
            cmd_step   = v[7:0];
            v = $urandom_range(0, 3);
            cmd_div    = v[PRESC_W-1:0];
        end
        ena = 1'b1; stop = 1'b0; cmd_valid = 1'b0;
        step_clk();
        $display("[TB] random phase done inc=%0d", inc_out);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
